// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the IF/MEM unified-memory arbiter.
//   state_t  : sequencer states (IDLE / WAIT / DONE)
//   owner_t  : requester that currently holds the memory (IF=0, MEM=1)
//   LAT_MIN / LAT_MAX : legal range of the memory read latency
//   CNT_W    : width of the latency down-counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-ported memory between the IF and MEM pipeline stages.
// One requester is granted at a time (round-robin on a tie), a single-cycle
// strobe is issued, the fixed read latency is counted down, the returned word
// is captured into the owner's response register, and the owner sees its stall
// drop for exactly one DONE cycle.
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   i_if_req / i_if_addr              IF read request and PC
//   o_if_rdata / o_if_stall           fetched word (valid in IF DONE), IF stall
//   i_mem_req / i_mem_we              MEM request and direction (1 = write)
//   i_mem_addr / i_mem_wdata          MEM address and store data
//   o_mem_rdata / o_mem_stall         load word (valid in MEM DONE), MEM stall
//   o_m_en / o_m_we                   registered memory strobe / write enable
//   o_m_addr / o_m_wdata              registered memory address / write data
//   i_m_rdata                         memory read data
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | memory free; arbitrate and grant on this edge
// WAIT    | access in flight; strobe in first cycle, then count latency
// DONE    | owner's stall released for one cycle; always back to IDLE
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LAT    = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_stall,

    input  logic              i_mem_req,
    input  logic              i_mem_we,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] o_mem_rdata,
    output logic              o_mem_stall,

    output logic              o_m_en,
    output logic              o_m_we,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_wdata,
    input  logic [DATA_W-1:0] i_m_rdata
);

    generate
        if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_lat_check
            $error("mem_arbiter: LAT=%0d outside legal range %0d..%0d", LAT, LAT_MIN, LAT_MAX);
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    owner_t             r_owner;
    owner_t             r_last;
    owner_t             w_grant_owner;
    logic               w_grant;
    logic               w_last_beat;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_m_en;
    logic               r_m_we;
    logic [ADDR_W-1:0]  r_m_addr;
    logic [DATA_W-1:0]  r_m_wdata;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_mem_rdata;

    // Round-robin: on a tie the requester that did not win last time goes.
    always_comb begin
        w_grant       = i_if_req | i_mem_req;
        w_grant_owner = OWN_IF;
        if (i_if_req && i_mem_req) begin
            w_grant_owner = (r_last == OWN_IF) ? OWN_MEM : OWN_IF;
        end else if (i_mem_req) begin
            w_grant_owner = OWN_MEM;
        end
    end

    // The counter holds during the strobe cycle, so the capture lands LAT
    // cycles after the edge that sampled the strobe.
    assign w_last_beat = !r_m_en && (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_grant) w_state_nxt = ST_WAIT;
            ST_WAIT: if (w_last_beat) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_if_stall  = i_if_req  & !((r_state == ST_DONE) && (r_owner == OWN_IF));
        o_mem_stall = i_mem_req & !((r_state == ST_DONE) && (r_owner == OWN_MEM));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= OWN_IF;
            r_last      <= OWN_IF;
            r_cnt       <= '0;
            r_m_en      <= 1'b0;
            r_m_we      <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner   <= w_grant_owner;
                        r_last    <= w_grant_owner;
                        r_cnt     <= CNT_W'(LAT);
                        r_m_en    <= 1'b1;
                        r_m_we    <= (w_grant_owner == OWN_MEM) & i_mem_we;
                        r_m_addr  <= (w_grant_owner == OWN_MEM) ? i_mem_addr : i_if_addr;
                        r_m_wdata <= (w_grant_owner == OWN_MEM) ? i_mem_wdata : '0;
                    end
                end
                ST_WAIT: begin
                    if (r_m_en) begin
                        r_m_en <= 1'b0;
                    end else if (w_last_beat) begin
                        r_cnt <= '0;
                        if (!r_m_we) begin
                            if (r_owner == OWN_IF) r_if_rdata  <= i_m_rdata;
                            else                   r_mem_rdata <= i_m_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_m_en      = r_m_en;
    assign o_m_we      = r_m_we;
    assign o_m_addr    = r_m_addr;
    assign o_m_wdata   = r_m_wdata;
    assign o_if_rdata  = r_if_rdata;
    assign o_mem_rdata = r_mem_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer that shares one single-ported unified memory between the instruction-fetch (IF) stage and the MEM stage of the pipelined MIPS core. It grants the memory to one requester at a time and issues a one-cycle access. It waits a fixed, parameterised read latency, captures the returned word, and holds the losing or waiting stage with a stall. It sits between the IF/MEM stages and the memory macro, in place of direct per-stage memory ports.

## Interface
- LAT, 2, memory read latency in cycles, from the edge that samples `m_en` to `m_rdata` being valid; legal range 1..15.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  IF read request; held until the cycle `if_stall` is low.
- if_addr  in  ADDR_W  IF read address (PC).
- if_rdata  out  DATA_W  fetched instruction; valid in the IF done cycle.
- if_stall  out  1  stall IF.
- mem_req  in  1  MEM access request (MemRead | MemWrite); held until `mem_stall` is low.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  ADDR_W  MEM address (ALU result).
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data; valid in the MEM done cycle.
- mem_stall  out  1  stall MEM.
- m_en  out  1  memory access strobe, registered.
- m_we  out  1  memory write enable, registered; qualified by `m_en`.
- m_addr  out  ADDR_W  memory address, registered.
- m_wdata  out  DATA_W  memory write data, registered.
- m_rdata  in  DATA_W  memory read data.

## Operation
- **States:** IDLE, WAIT, DONE. `owner` ∈ {IF, MEM}. `last` holds the owner of the previous grant.
- **IDLE:**
  - With no request, remain in IDLE.
  - With exactly one request, grant that requester.
  - With both requesting, grant the requester that is not `last` (round-robin).
  - On a grant at the clock edge:
    - `m_en`=1, `m_we` = (owner==MEM) & `mem_we`.
    - `m_addr` and `m_wdata` are taken from the owner's inputs.
    - `cnt` is loaded with LAT.
    - `last` is set to the owner.
    - The state moves to WAIT.
- **WAIT:**
  - `m_en`=0 from the second WAIT cycle onward, so the strobe is exactly one cycle.
  - `cnt` decrements each cycle.
  - In the cycle where `cnt`==1, `m_rdata` is registered into the owner's response register and the state moves to DONE.
  - On a write, the response register is not updated.
- **DONE:**
  - The owner's stall is low for exactly this cycle.
  - The next state is always IDLE. There is no chained grant, so one IDLE cycle separates accesses.
- **Stall outputs (combinational):**
  - `if_stall` = `if_req` & !(DONE & owner==IF).
  - `mem_stall` = `mem_req` & !(DONE & owner==MEM).
  - The non-owner stays stalled throughout.
- **Request withdrawal:** a request dropped during WAIT (flush) does not abort the access. The access completes, the DONE cycle still occurs, and the response is ignored by the stage.
- **Response hold:** `if_rdata` and `mem_rdata` keep their last captured value between accesses.
- **Write-then-fetch ordering:** strict, because accesses never overlap.

## Timing
- Request high in IDLE at cycle 0:
  - `m_en` high in cycle 1.
  - `m_rdata` sampled at the end of cycle LAT+1.
  - Stall low and data valid in cycle LAT+2.
  - Total: LAT+2 stalled cycles, then one done cycle.
- **Both requesting:** the second requester's done cycle is 2·(LAT+2)+1 cycles after cycle 0.
- **Reset (`rst_n`=0), applied immediately and asynchronously:**
  - State IDLE, `cnt`=0, `last`=IF (so MEM wins the first tie).
  - `m_en`, `m_we`, `m_addr`, `m_wdata` = 0.
  - `if_rdata`, `mem_rdata` = 0.
  - Stall outputs follow their requests, i.e. a requester sees stall=1 while reset is held.
- **Reset during WAIT:** the in-flight access is abandoned with no DONE cycle. A write whose strobe has already been issued is considered performed. After release, pending requests re-arbitrate from IDLE.
- **Counter width:** `cnt` is 4 bits; LAT=15 does not wrap.

## Structure
- Package `mem_arb_pkg`:
  - state enum (IDLE/WAIT/DONE);
  - owner encoding (IF=0, MEM=1);
  - LAT legal-range constants.
- Single module. The latency counter is inline; a separate sub-module is not warranted.
- An elaboration-time check rejects LAT outside 1..15.

## Test plan
- **Reset:** hold `rst_n`=0 with `if_req`=`mem_req`=1 → `m_en`=0, rdata outputs 0, both stalls 1; on release, MEM is granted first.
- **IF read, LAT=2:** `if_addr`=0x40, `m_rdata`=0xDEADBEEF valid in cycle 3 → `m_en`/`m_addr`=0x40 in cycle 1 only; `if_stall` is 1 in cycles 0–3 and 0 in cycle 4 with `if_rdata`=0xDEADBEEF.
- **MEM write:** `mem_we`=1, `mem_addr`=0x10, `mem_wdata`=0x1234 → cycle 1 has `m_en`=`m_we`=1, `m_addr`=0x10, `m_wdata`=0x1234; `mem_stall` low in cycle 4; `mem_rdata` unchanged.
- **Simultaneous requests after reset, LAT=2:** MEM done in cycle 4, IDLE in cycle 5, IF `m_en` in cycle 6, IF done in cycle 9.
- **Fairness:** `mem_req` re-asserted every cycle with `if_req` held → grants alternate MEM, IF, MEM, IF; IF is never starved.
- **Mid-access reset:** deassert `rst_n` in the first WAIT cycle → `m_en`=0 immediately, no stall-low pulse; after release, the held request is re-issued and completes LAT+2 cycles later.
